// File: rtl/multiplexer_2to1_pkg.sv
// Shared defaults for the 2:1 selector slice; the top keeps WIDTH and CNT_W
// as its own parameters and only borrows these as default values.
package multiplexer_2to1_pkg;

   localparam int DEFAULT_WIDTH = 1;
   localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/multiplexer_2to1_mux2_comb.sv
// Purely combinational 2:1 selector. An unknown select merges the inputs:
// bits where in0 and in1 agree keep that value, every other bit goes X.
module mux2_comb #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] in0_i,
   input  logic [WIDTH-1:0] in1_i,
   input  logic             sel_i,
   output logic [WIDTH-1:0] out_o
);

   // The conditional operator already applies the bitwise merge for an unknown select.
   assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/multiplexer_2to1.sv
// 2:1 selector with registered copies of its output and select, plus a
// saturating counter of clock edges on which select changed.
import multiplexer_2to1_pkg::*;

module multiplexer_2to1 #(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   output logic [WIDTH-1:0] out,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i0,
   input  logic             select,
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] out_q,
   output logic             select_q,
   output logic [CNT_W-1:0] toggles
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] muxOut;
   logic [WIDTH-1:0] dataOut_q;
   logic             sel_q;
   logic [CNT_W-1:0] toggleCnt_q;
   logic [CNT_W-1:0] toggleCnt_d;

   mux2_comb #(
      .WIDTH (WIDTH)
   ) uMux (
      .in0_i (i0),
      .in1_i (i1),
      .sel_i (select),
      .out_o (muxOut)
   );

   // Count a toggle whenever the live select differs from last edge's value,
   // holding at the top instead of wrapping.
   always_comb begin
      toggleCnt_d = toggleCnt_q;
      if ((select != sel_q) && (toggleCnt_q != CNT_MAX)) begin
         toggleCnt_d = toggleCnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dataOut_q   <= '0;
         sel_q       <= 1'b0;
         toggleCnt_q <= '0;
      end else begin
         dataOut_q   <= muxOut;
         sel_q       <= select;
         toggleCnt_q <= toggleCnt_d;
      end
   end

   assign out      = muxOut;
   assign out_q    = dataOut_q;
   assign select_q = sel_q;
   assign toggles  = toggleCnt_q;

endmodule

// File: tb/tb_multiplexer_2to1.sv
// Self-checking bench: an 8-bit/2-bit-counter instance and a default
// 1-bit/8-bit-counter instance share stimulus and a behavioural model.
module tb_multiplexer_2to1;

   logic       clk = 1'b0;
   logic       clkEn = 1'b0;
   logic       rst;
   logic [7:0] i0;
   logic [7:0] i1;
   logic       select;

   logic [7:0] outA, outQA;
   logic       selQA;
   logic [1:0] togglesA;
   logic       outB, outQB, selQB;
   logic [7:0] togglesB;

   int total = 0;
   int bad = 0;

   // Reference state: what the registered outputs should read right now.
   logic [7:0] modelOutQ;
   logic       modelSelQ;
   int         modelCntA;
   int         modelCntB;

   typedef struct {
      logic       sel;
      logic [7:0] a0;
      logic [7:0] a1;
      logic [7:0] expOut;
   } combVec_t;

   combVec_t combTable[6];
   int       toggleExpA[6];

   always #5 if (clkEn) clk = ~clk;

   multiplexer_2to1 #(.WIDTH(8), .CNT_W(2)) dutA (
      .out      (outA),
      .i1       (i1),
      .i0       (i0),
      .select   (select),
      .clk      (clk),
      .rst      (rst),
      .out_q    (outQA),
      .select_q (selQA),
      .toggles  (togglesA)
   );

   multiplexer_2to1 dutB (
      .out      (outB),
      .i1       (i1[0]),
      .i0       (i0[0]),
      .select   (select),
      .clk      (clk),
      .rst      (rst),
      .out_q    (outQB),
      .select_q (selQB),
      .toggles  (togglesB)
   );

   function automatic logic [7:0] refMux(logic s, logic [7:0] a0, logic [7:0] a1);
      return (s == 1'b1) ? a1 : a0;
   endfunction

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, wanted %h", name, act, exp);
      end
   endtask

   task automatic resetModel();
      modelOutQ = '0;
      modelSelQ = 1'b0;
      modelCntA = 0;
      modelCntB = 0;
   endtask

   // Advance the model by one rising edge using the inputs presented now,
   // then let the DUT see that edge and settle.
   task automatic applyStimulus();
      if (!rst) begin
         if (select != modelSelQ) begin
            modelCntA = (modelCntA + 1 > 3)   ? 3   : modelCntA + 1;
            modelCntB = (modelCntB + 1 > 255) ? 255 : modelCntB + 1;
         end
         modelOutQ = refMux(select, i0, i1);
         modelSelQ = select;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic checkAll(string tag);
      checkOutput({tag, ".outA"},     32'(outA),     32'(refMux(select, i0, i1)));
      checkOutput({tag, ".outB"},     32'(outB),     32'(refMux(select, i0, i1) & 8'h01));
      checkOutput({tag, ".outQA"},    32'(outQA),    32'(modelOutQ));
      checkOutput({tag, ".outQB"},    32'(outQB),    32'(modelOutQ[0]));
      checkOutput({tag, ".selQA"},    32'(selQA),    32'(modelSelQ));
      checkOutput({tag, ".selQB"},    32'(selQB),    32'(modelSelQ));
      checkOutput({tag, ".togglesA"}, 32'(togglesA), 32'(modelCntA));
      checkOutput({tag, ".togglesB"}, 32'(togglesB), 32'(modelCntB));
   endtask

   initial begin
      logic [7:0] mask;

      combTable[0] = '{1'b0, 8'h01, 8'h00, 8'h01};
      combTable[1] = '{1'b1, 8'h01, 8'h00, 8'h00};
      combTable[2] = '{1'b1, 8'h01, 8'h01, 8'h01};
      combTable[3] = '{1'b0, 8'hA5, 8'h3C, 8'hA5};
      combTable[4] = '{1'b1, 8'hA5, 8'h3C, 8'h3C};
      combTable[5] = '{1'b1, 8'hFF, 8'h80, 8'h80};
      toggleExpA   = '{1, 2, 3, 3, 3, 3};

      // Reset held, no clock: everything zero, out already valid.
      rst = 1'b1; select = 1'b0; i0 = 8'h00; i1 = 8'h00;
      resetModel();
      #1;
      checkOutput("rst.out", 32'(outA), 32'h0);
      checkAll("rst");

      // Combinational path stepped with no clock running.
      for (int k = 0; k < 6; k++) begin
         #9;
         select = combTable[k].sel;
         i0     = combTable[k].a0;
         i1     = combTable[k].a1;
         #1;
         checkOutput($sformatf("comb%0d.outA", k), 32'(outA), 32'(combTable[k].expOut));
         checkOutput($sformatf("comb%0d.outB", k), 32'(outB), 32'(combTable[k].expOut[0]));
         checkOutput($sformatf("comb%0d.regs", k), 32'({outQA, selQA, togglesA}), 32'h0);
      end

      // Release reset between edges, then the basic registered sequence.
      clkEn = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; select = 1'b0; i0 = 8'h01; i1 = 8'h00;
      applyStimulus();
      checkOutput("seq.outQ1", 32'(outQA), 32'h01);
      checkAll("seq1");
      select = 1'b1; i1 = 8'h00;
      applyStimulus();
      checkOutput("seq.outQ2", 32'(outQA), 32'h00);
      checkOutput("seq.selQ2", 32'(selQA), 32'h1);
      checkOutput("seq.tog2",  32'(togglesA), 32'h1);
      checkAll("seq2");

      // Fresh reset, then toggle select on every edge to saturate dutA.
      rst = 1'b1; #1; rst = 1'b0; resetModel();
      select = 1'b0;
      for (int k = 0; k < 6; k++) begin
         select = ~select;
         i0 = 8'(k);
         i1 = 8'(k + 8'h40);
         applyStimulus();
         checkOutput($sformatf("sat%0d.togglesA", k), 32'(togglesA), 32'(toggleExpA[k]));
         checkAll($sformatf("sat%0d", k));
      end

      // Mid-count async reset: clears without an edge while out keeps tracking.
      #2;
      rst = 1'b1;
      #1;
      resetModel();
      checkOutput("async.regsA", 32'({outQA, selQA, togglesA}), 32'h0);
      checkOutput("async.togglesB", 32'(togglesB), 32'h0);
      i0 = 8'h5A; select = 1'b0;
      #1;
      checkOutput("async.outTrack", 32'(outA), 32'h5A);
      checkAll("async");
      applyStimulus();
      checkAll("asyncHeld");

      // Unknown select: agreeing bits must come through from the inputs.
      select = 1'bx; i0 = 8'hA5; i1 = 8'h3C;
      #1;
      mask = ~(i0 ^ i1);
      checkOutput("xsel.agree", 32'(outA & mask), 32'(i0 & mask));
      select = 1'b0;
      #1;

      // Randomised run long enough to saturate dutB's 8-bit counter.
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 600; k++) begin
         i0     = 8'($urandom);
         i1     = 8'($urandom);
         select = 1'($urandom);
         #1;
         checkOutput("rand.comb", 32'(outA), 32'(refMux(select, i0, i1)));
         applyStimulus();
         checkAll("rand");
      end
      checkOutput("rand.satB", 32'(togglesB), 32'd255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
